// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared LCD / frame-buffer constants and grant encoding
package lcd_pkg;

    localparam int H_PIXELS = 800;
    localparam int V_PIXELS = 480;

    localparam int ABW_DEF = 19;
    localparam int DW_DEF  = 24;

    // Owner of a VRAM slot; also used as the tag in the read-return pipeline
    typedef enum logic [1:0] {
        G_IDLE,
        G_DISP,
        G_WDRAIN,
        G_HRD
    } grantT;

endpackage

// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - display, host and VRAM signals of the arbiter
interface vram_arbiter_if
    import lcd_pkg::*;
#(
    parameter int ABW = ABW_DEF,
    parameter int DW  = DW_DEF
) ();

    logic           iDISP_REQ;
    logic [ABW-1:0] iDISP_ADDR;
    logic [DW-1:0]  oDISP_COLOR;
    logic           oDISP_VALID;

    logic           iHOST_REQ;
    logic           iHOST_WE;
    logic [ABW-1:0] iHOST_ADDR;
    logic [DW-1:0]  iHOST_WDATA;
    logic           oHOST_ACK;
    logic [DW-1:0]  oHOST_RDATA;
    logic           oHOST_STARVE;
    logic           iSTARVE_CLR;

    logic [ABW-1:0] oMEM_ADDR;
    logic           oMEM_WE;
    logic [DW-1:0]  oMEM_WDATA;
    logic [DW-1:0]  iMEM_RDATA;

    // Arbiter side
    modport slave (
        input  iDISP_REQ, iDISP_ADDR, iHOST_REQ, iHOST_WE, iHOST_ADDR,
               iHOST_WDATA, iSTARVE_CLR, iMEM_RDATA,
        output oDISP_COLOR, oDISP_VALID, oHOST_ACK, oHOST_RDATA,
               oHOST_STARVE, oMEM_ADDR, oMEM_WE, oMEM_WDATA
    );

    // Requesters and memory side
    modport master (
        output iDISP_REQ, iDISP_ADDR, iHOST_REQ, iHOST_WE, iHOST_ADDR,
               iHOST_WDATA, iSTARVE_CLR, iMEM_RDATA,
        input  oDISP_COLOR, oDISP_VALID, oHOST_ACK, oHOST_RDATA,
               oHOST_STARVE, oMEM_ADDR, oMEM_WE, oMEM_WDATA
    );

endinterface

// File: rtl/vram_wbuf.sv
// rtl/vram_wbuf.sv - one-entry posted host write buffer
module vram_wbuf
    import lcd_pkg::*;
#(
    parameter int ABW = ABW_DEF,
    parameter int DW  = DW_DEF
) (
    input  logic           clk,
    input  logic           rst_,
    input  logic           load,
    input  logic           drain,
    input  logic [ABW-1:0] wrAddr,
    input  logic [DW-1:0]  wrData,
    output logic           full,
    output logic [ABW-1:0] addr,
    output logic [DW-1:0]  data
);

    // A load in the same edge as a drain refills the entry, so load wins
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            full <= 1'b0;
            addr <= '0;
            data <= '0;
        end else if (load) begin
            full <= 1'b1;
            addr <= wrAddr;
            data <= wrData;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM arbiter between LCD scan-out and host
module vram_arbiter
    import lcd_pkg::*;
#(
    parameter int ABW        = ABW_DEF,
    parameter int DW         = DW_DEF,
    parameter int STARVE_LIM = 64
) (
    input logic           clk,
    input logic           rst_,
    vram_arbiter_if.slave bus
);

    localparam int CW = $clog2(STARVE_LIM + 1);

    grantT          grant;
    grantT          tag0;
    grantT          tag1;
    logic           hostLive;
    logic           load;
    logic           drain;
    logic           ackNext;
    logic           hrdBusy;
    logic           wbFull;
    logic [ABW-1:0] wbAddr;
    logic [DW-1:0]  wbData;
    logic [CW-1:0]  starveCnt;
    logic [CW-1:0]  starveCntNext;
    logic           starveSet;

    // A request seen while ACK is high is the turnaround cycle and is ignored
    assign hostLive = bus.iHOST_REQ && !bus.oHOST_ACK;
    assign drain    = (grant == G_WDRAIN);
    assign load     = hostLive && bus.iHOST_WE && (!wbFull || drain);
    assign ackNext  = load || (tag1 == G_HRD);

    // Fixed priority: display, buffer drain, then host read (only with empty buffer)
    always_comb begin
        grant = G_IDLE;
        if (bus.iDISP_REQ) begin
            grant = G_DISP;
        end else if (wbFull) begin
            grant = G_WDRAIN;
        end else if (hostLive && !bus.iHOST_WE && !hrdBusy) begin
            grant = G_HRD;
        end
    end

    vram_wbuf #(.ABW(ABW), .DW(DW)) u_wbuf (
        .clk    (clk),
        .rst_   (rst_),
        .load   (load),
        .drain  (drain),
        .wrAddr (bus.iHOST_ADDR),
        .wrData (bus.iHOST_WDATA),
        .full   (wbFull),
        .addr   (wbAddr),
        .data   (wbData)
    );

    // Register the winning access onto the VRAM port; idle slots hold the address
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            bus.oMEM_ADDR  <= '0;
            bus.oMEM_WE    <= 1'b0;
            bus.oMEM_WDATA <= '0;
        end else begin
            bus.oMEM_WE <= 1'b0;
            case (grant)
                G_DISP:   bus.oMEM_ADDR <= bus.iDISP_ADDR;
                G_HRD:    bus.oMEM_ADDR <= bus.iHOST_ADDR;
                G_WDRAIN: begin
                    bus.oMEM_ADDR  <= wbAddr;
                    bus.oMEM_WE    <= 1'b1;
                    bus.oMEM_WDATA <= wbData;
                end
                default:  ;
            endcase
        end
    end

    // Two-stage grant tag pipeline steers returning VRAM data to display or host
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            tag0            <= G_IDLE;
            tag1            <= G_IDLE;
            hrdBusy         <= 1'b0;
            bus.oDISP_VALID <= 1'b0;
            bus.oDISP_COLOR <= '0;
            bus.oHOST_ACK   <= 1'b0;
            bus.oHOST_RDATA <= '0;
        end else begin
            tag0            <= grant;
            tag1            <= tag0;
            bus.oDISP_VALID <= (tag1 == G_DISP);
            bus.oHOST_ACK   <= ackNext;
            if (tag1 == G_DISP) begin
                bus.oDISP_COLOR <= bus.iMEM_RDATA;
            end
            if (tag1 == G_HRD) begin
                bus.oHOST_RDATA <= bus.iMEM_RDATA;
                hrdBusy         <= 1'b0;
            end else if (grant == G_HRD) begin
                hrdBusy <= 1'b1;
            end
        end
    end

    // Waiting-cycle count: cleared by ACK, saturates at the limit
    always_comb begin
        starveCntNext = starveCnt;
        if (ackNext) begin
            starveCntNext = '0;
        end else if (hostLive && (starveCnt != CW'(STARVE_LIM))) begin
            starveCntNext = starveCnt + 1'b1;
        end
    end

    assign starveSet = (starveCntNext == CW'(STARVE_LIM));

    // Sticky starvation flag; a set in the same cycle as a clear wins
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            starveCnt        <= '0;
            bus.oHOST_STARVE <= 1'b0;
        end else begin
            starveCnt <= starveCntNext;
            if (starveSet) begin
                bus.oHOST_STARVE <= 1'b1;
            end else if (bus.iSTARVE_CLR) begin
                bus.oHOST_STARVE <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - directed self-checking bench for vram_arbiter
module tb_vram_arbiter;
    import lcd_pkg::*;

    localparam int ABW = 19;
    localparam int DW  = 24;

    logic clk  = 1'b0;
    logic rst_ = 1'b0;
    int   nChecks = 0;
    int   nFail   = 0;

    logic [DW-1:0] mem [0:1023];
    logic          memReady = 1'b0;

    always #5 clk = ~clk;

    vram_arbiter_if #(.ABW(ABW), .DW(DW)) bus ();

    vram_arbiter #(.ABW(ABW), .DW(DW), .STARVE_LIM(64)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus)
    );

    // Synchronous VRAM model, one-cycle read latency, preloaded with mem[i] = i
    always @(posedge clk) begin
        if (!memReady) begin
            for (int i = 0; i < 1024; i++) mem[i] <= DW'(i);
            memReady <= 1'b1;
        end else if (bus.oMEM_WE) begin
            mem[bus.oMEM_ADDR[9:0]] <= bus.oMEM_WDATA;
        end
        bus.iMEM_RDATA <= mem[bus.oMEM_ADDR[9:0]];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        nChecks++; if (bus.oDISP_VALID !== 1'b0) begin nFail++; $display("FAIL reset_disp_valid: got %0h want 0", bus.oDISP_VALID); end
        nChecks++; if (bus.oDISP_COLOR !== '0) begin nFail++; $display("FAIL reset_disp_color: got %0h want 0", bus.oDISP_COLOR); end
        nChecks++; if (bus.oHOST_ACK !== 1'b0) begin nFail++; $display("FAIL reset_host_ack: got %0h want 0", bus.oHOST_ACK); end
        nChecks++; if (bus.oHOST_RDATA !== '0) begin nFail++; $display("FAIL reset_host_rdata: got %0h want 0", bus.oHOST_RDATA); end
        nChecks++; if (bus.oHOST_STARVE !== 1'b0) begin nFail++; $display("FAIL reset_starve: got %0h want 0", bus.oHOST_STARVE); end
        nChecks++; if (bus.oMEM_ADDR !== '0) begin nFail++; $display("FAIL reset_mem_addr: got %0h want 0", bus.oMEM_ADDR); end
        nChecks++; if (bus.oMEM_WE !== 1'b0) begin nFail++; $display("FAIL reset_mem_we: got %0h want 0", bus.oMEM_WE); end
        nChecks++; if (bus.oMEM_WDATA !== '0) begin nFail++; $display("FAIL reset_mem_wdata: got %0h want 0", bus.oMEM_WDATA); end
        rst_ = 1'b1;
    endtask

    task automatic test_display_only();
        for (int c = 0; c < 11; c++) begin
            bus.iDISP_REQ  = (c < 8);
            bus.iDISP_ADDR = ABW'(c);
            step();
            nChecks++;
            if (bus.oDISP_VALID !== ((c >= 2) && (c < 10))) begin
                nFail++; $display("FAIL disp_valid c=%0d: got %0h want %0h", c, bus.oDISP_VALID, ((c >= 2) && (c < 10)));
            end
            if ((c >= 2) && (c < 10)) begin
                nChecks++;
                if (bus.oDISP_COLOR !== DW'(c - 2)) begin
                    nFail++; $display("FAIL disp_color c=%0d: got %0h want %0h", c, bus.oDISP_COLOR, c - 2);
                end
            end
            if (c < 8) begin
                nChecks++;
                if (bus.oMEM_ADDR !== ABW'(c)) begin
                    nFail++; $display("FAIL disp_mem_addr c=%0d: got %0h want %0h", c, bus.oMEM_ADDR, c);
                end
            end
            nChecks++;
            if (bus.oMEM_WE !== 1'b0) begin nFail++; $display("FAIL disp_mem_we c=%0d: got %0h want 0", c, bus.oMEM_WE); end
        end
        bus.iDISP_REQ = 1'b0;
    endtask

    task automatic test_write_read();
        bus.iHOST_REQ   = 1'b1;
        bus.iHOST_WE    = 1'b1;
        bus.iHOST_ADDR  = ABW'(100);
        bus.iHOST_WDATA = 24'h00ABCD;
        step();
        nChecks++; if (bus.oHOST_ACK !== 1'b1) begin nFail++; $display("FAIL wr_ack: got %0h want 1", bus.oHOST_ACK); end
        nChecks++; if (bus.oMEM_WE !== 1'b0) begin nFail++; $display("FAIL wr_no_early_drain: got %0h want 0", bus.oMEM_WE); end
        // read presented during the ACK cycle; a display request delays the drain
        bus.iHOST_WE   = 1'b0;
        bus.iDISP_REQ  = 1'b1;
        bus.iDISP_ADDR = ABW'(5);
        step();
        nChecks++; if (bus.oHOST_ACK !== 1'b0) begin nFail++; $display("FAIL wr_ack_pulse: got %0h want 0", bus.oHOST_ACK); end
        nChecks++; if ((bus.oMEM_WE !== 1'b0) || (bus.oMEM_ADDR !== ABW'(5))) begin
            nFail++; $display("FAIL wr_disp_first: got we=%0h addr=%0h want we=0 addr=5", bus.oMEM_WE, bus.oMEM_ADDR);
        end
        bus.iDISP_REQ = 1'b0;
        step();
        nChecks++; if ((bus.oMEM_WE !== 1'b1) || (bus.oMEM_ADDR !== ABW'(100)) || (bus.oMEM_WDATA !== 24'h00ABCD)) begin
            nFail++; $display("FAIL wr_drain: got we=%0h addr=%0h data=%0h want we=1 addr=64 data=abcd", bus.oMEM_WE, bus.oMEM_ADDR, bus.oMEM_WDATA);
        end
        step();
        nChecks++; if ((bus.oMEM_WE !== 1'b0) || (bus.oMEM_ADDR !== ABW'(100))) begin
            nFail++; $display("FAIL rd_issue: got we=%0h addr=%0h want we=0 addr=64", bus.oMEM_WE, bus.oMEM_ADDR);
        end
        nChecks++; if ((bus.oDISP_VALID !== 1'b1) || (bus.oDISP_COLOR !== DW'(5))) begin
            nFail++; $display("FAIL rd_disp_return: got valid=%0h color=%0h want valid=1 color=5", bus.oDISP_VALID, bus.oDISP_COLOR);
        end
        step();
        nChecks++; if (bus.oHOST_ACK !== 1'b0) begin nFail++; $display("FAIL rd_ack_early: got %0h want 0", bus.oHOST_ACK); end
        step();
        nChecks++; if ((bus.oHOST_ACK !== 1'b1) || (bus.oHOST_RDATA !== 24'h00ABCD)) begin
            nFail++; $display("FAIL rd_ack_data: got ack=%0h data=%0h want ack=1 data=abcd", bus.oHOST_ACK, bus.oHOST_RDATA);
        end
        bus.iHOST_REQ = 1'b0;
        step();
        nChecks++; if (bus.oHOST_ACK !== 1'b0) begin nFail++; $display("FAIL rd_ack_pulse: got %0h want 0", bus.oHOST_ACK); end
        nChecks++; if (mem[100] !== 24'h00ABCD) begin nFail++; $display("FAIL wr_landed: got %0h want abcd", mem[100]); end
    endtask

    task automatic test_interleave();
        int wrIdx = 0;
        int acks = 0;
        int lastAck = -10;
        int bad = 0;
        logic h0 = 1'b0, h1 = 1'b0, h2 = 1'b0;
        int a0 = 0, a1 = 0, a2 = 0;
        for (int c = 0; c < 80; c++) begin
            bus.iDISP_REQ  = ((c % 2) == 0);
            bus.iDISP_ADDR = ABW'(200 + (c % 16));
            if (wrIdx < 16) begin
                bus.iHOST_REQ   = 1'b1;
                bus.iHOST_WE    = 1'b1;
                bus.iHOST_ADDR  = ABW'(wrIdx);
                bus.iHOST_WDATA = DW'(256 + wrIdx);
            end else begin
                bus.iHOST_REQ = 1'b0;
            end
            step();
            h2 = h1; h1 = h0; h0 = ((c % 2) == 0);
            a2 = a1; a1 = a0; a0 = 200 + (c % 16);
            nChecks++;
            if (bus.oDISP_VALID !== h2) begin
                nFail++; $display("FAIL il_disp_valid c=%0d: got %0h want %0h", c, bus.oDISP_VALID, h2);
            end
            if (h2) begin
                nChecks++;
                if (bus.oDISP_COLOR !== DW'(a2)) begin
                    nFail++; $display("FAIL il_disp_color c=%0d: got %0h want %0h", c, bus.oDISP_COLOR, a2);
                end
            end
            if (bus.oHOST_ACK) begin
                acks++;
                nChecks++;
                if ((c - lastAck) < 2) begin
                    nFail++; $display("FAIL il_ack_spacing c=%0d: got %0d want >=2", c, c - lastAck);
                end
                lastAck = c;
                wrIdx++;
            end
        end
        bus.iHOST_REQ = 1'b0;
        bus.iDISP_REQ = 1'b0;
        repeat (4) step();
        nChecks++; if (acks !== 16) begin nFail++; $display("FAIL il_ack_count: got %0d want 16", acks); end
        for (int i = 0; i < 16; i++) if (mem[i] !== DW'(256 + i)) bad++;
        nChecks++; if (bad !== 0) begin nFail++; $display("FAIL il_writes_landed: got %0d bad words want 0", bad); end
    endtask

    task automatic test_starvation();
        int ackSeen = 0;
        bus.iHOST_REQ  = 1'b1;
        bus.iHOST_WE   = 1'b0;
        bus.iHOST_ADDR = ABW'(100);
        bus.iDISP_REQ  = 1'b1;
        bus.iDISP_ADDR = ABW'(7);
        for (int c = 1; c <= 70; c++) begin
            bus.iSTARVE_CLR = (c == 66);
            step();
            if (bus.oHOST_ACK) ackSeen++;
            if (c == 63) begin
                nChecks++; if (bus.oHOST_STARVE !== 1'b0) begin nFail++; $display("FAIL starve_early: got %0h want 0", bus.oHOST_STARVE); end
            end
            if (c == 64) begin
                nChecks++; if (bus.oHOST_STARVE !== 1'b1) begin nFail++; $display("FAIL starve_set: got %0h want 1", bus.oHOST_STARVE); end
            end
            if (c == 66) begin
                nChecks++; if (bus.oHOST_STARVE !== 1'b1) begin nFail++; $display("FAIL starve_set_wins: got %0h want 1", bus.oHOST_STARVE); end
            end
        end
        bus.iSTARVE_CLR = 1'b0;
        nChecks++; if (ackSeen !== 0) begin nFail++; $display("FAIL starve_no_ack: got %0d want 0", ackSeen); end
        bus.iDISP_REQ = 1'b0;
        step();
        nChecks++; if ((bus.oMEM_ADDR !== ABW'(100)) || (bus.oMEM_WE !== 1'b0)) begin
            nFail++; $display("FAIL starve_rd_issue: got addr=%0h we=%0h want addr=64 we=0", bus.oMEM_ADDR, bus.oMEM_WE);
        end
        step();
        nChecks++; if (bus.oHOST_ACK !== 1'b0) begin nFail++; $display("FAIL starve_ack_early: got %0h want 0", bus.oHOST_ACK); end
        step();
        nChecks++; if ((bus.oHOST_ACK !== 1'b1) || (bus.oHOST_RDATA !== 24'h00ABCD)) begin
            nFail++; $display("FAIL starve_rd_done: got ack=%0h data=%0h want ack=1 data=abcd", bus.oHOST_ACK, bus.oHOST_RDATA);
        end
        bus.iHOST_REQ = 1'b0;
        step();
        nChecks++; if (bus.oHOST_STARVE !== 1'b1) begin nFail++; $display("FAIL starve_sticky: got %0h want 1", bus.oHOST_STARVE); end
        bus.iSTARVE_CLR = 1'b1;
        step();
        bus.iSTARVE_CLR = 1'b0;
        nChecks++; if (bus.oHOST_STARVE !== 1'b0) begin nFail++; $display("FAIL starve_clear: got %0h want 0", bus.oHOST_STARVE); end
    endtask

    task automatic test_reset_midop();
        int stray = 0;
        bus.iDISP_REQ   = 1'b1;
        bus.iDISP_ADDR  = ABW'(9);
        bus.iHOST_REQ   = 1'b1;
        bus.iHOST_WE    = 1'b1;
        bus.iHOST_ADDR  = ABW'(300);
        bus.iHOST_WDATA = 24'h00DEAD;
        step();
        bus.iHOST_REQ = 1'b0;
        step();
        rst_ = 1'b0;
        #1;
        nChecks++; if ((bus.oHOST_ACK !== 1'b0) || (bus.oDISP_VALID !== 1'b0) || (bus.oHOST_STARVE !== 1'b0)) begin
            nFail++; $display("FAIL midrst_flags: got ack=%0h valid=%0h starve=%0h want 0", bus.oHOST_ACK, bus.oDISP_VALID, bus.oHOST_STARVE);
        end
        nChecks++; if ((bus.oMEM_ADDR !== '0) || (bus.oMEM_WE !== 1'b0) || (bus.oMEM_WDATA !== '0)) begin
            nFail++; $display("FAIL midrst_mem: got addr=%0h we=%0h data=%0h want 0", bus.oMEM_ADDR, bus.oMEM_WE, bus.oMEM_WDATA);
        end
        nChecks++; if ((bus.oDISP_COLOR !== '0) || (bus.oHOST_RDATA !== '0)) begin
            nFail++; $display("FAIL midrst_data: got color=%0h rdata=%0h want 0", bus.oDISP_COLOR, bus.oHOST_RDATA);
        end
        bus.iDISP_REQ = 1'b0;
        repeat (2) step();
        rst_ = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            if (bus.oHOST_ACK || bus.oDISP_VALID || bus.oMEM_WE) stray++;
        end
        nChecks++; if (stray !== 0) begin nFail++; $display("FAIL midrst_stray: got %0d events want 0", stray); end
        nChecks++; if (mem[300] !== DW'(300)) begin nFail++; $display("FAIL midrst_no_write: got %0h want 12c", mem[300]); end
    endtask

    initial begin
        bus.iDISP_REQ   = 1'b0;
        bus.iDISP_ADDR  = '0;
        bus.iHOST_REQ   = 1'b0;
        bus.iHOST_WE    = 1'b0;
        bus.iHOST_ADDR  = '0;
        bus.iHOST_WDATA = '0;
        bus.iSTARVE_CLR = 1'b0;
        test_reset();
        test_display_only();
        test_write_read();
        test_interleave();
        test_starvation();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the single-port frame-buffer VRAM between the LCD scan-out path and a host (CPU/blitter) requester. The display always wins, and its reads have a fixed latency. Host writes are posted through a one-entry write buffer. Host reads use a req/ack handshake and are served in cycles the display leaves free. The block sits between the LCD controller's address/colour ports and the VRAM macro.

## Interface
Parameters:
- ABW, 19, VRAM word-address width (800×480 = 384000 words).
- DW, 24, pixel width (RGB888).
- STARVE_LIM, 64, number of consecutive waiting cycles of a pending host request before the starvation flag sets.

Ports:
- Clock and reset (already decided): one clock; reset is asynchronous and active-low.
  - clk  in  1  system clock; sole clock of the block.
  - rst_  in  1  asynchronous reset, active low.
- Display side:
  - iDISP_REQ  in  1  display read request strobe, one cycle per pixel.
  - iDISP_ADDR  in  ABW  display read address.
  - oDISP_COLOR  out  DW  read pixel.
  - oDISP_VALID  out  1  oDISP_COLOR valid, one-cycle pulse.
- Host side:
  - iHOST_REQ  in  1  host request, held until ack.
  - iHOST_WE  in  1  1 = write, 0 = read.
  - iHOST_ADDR  in  ABW  host address.
  - iHOST_WDATA  in  DW  host write data.
  - oHOST_ACK  out  1  one-cycle acknowledge.
  - oHOST_RDATA  out  DW  read data, valid with ACK on reads.
  - oHOST_STARVE  out  1  sticky starvation flag.
  - iSTARVE_CLR  in  1  clears oHOST_STARVE.
- Memory side:
  - oMEM_ADDR  out  ABW  VRAM address.
  - oMEM_WE  out  1  VRAM write enable.
  - oMEM_WDATA  out  DW  VRAM write data.
  - iMEM_RDATA  in  DW  VRAM read data, one cycle after address.

## Operation
- Reset values: all outputs are 0, the write buffer is empty, the starvation counter is 0.
- Arbitration at each rising edge, in priority order:
  1. iDISP_REQ → display read.
  2. Write buffer full → drain (memory write).
  3. Host read pending, not yet granted, and buffer empty → host read.
  4. Otherwise the slot is idle (oMEM_WE=0, address holds).
- Host write:
  - Accepted when the buffer is empty, or when it drains in this same edge.
  - Captures ADDR/WDATA and pulses oHOST_ACK in the next cycle.
  - If the buffer is full and not draining, the request waits.
- Host read:
  - Waits until the write buffer is empty. This gives read-after-write ordering without forwarding.
  - oHOST_ACK and oHOST_RDATA arrive together.
- A host REQ sampled while oHOST_ACK is high is ignored (one-cycle turnaround). The host deasserts or re-presents after that cycle.
- A display read of an address held in the buffer returns the old VRAM data. Tearing is accepted.
- Starvation:
  - The counter increments on every cycle a host request is pending and unserved, and resets on ACK.
  - It saturates at STARVE_LIM, which sets oHOST_STARVE.
  - The flag stays set until iSTARVE_CLR; a clear in the same cycle as a set loses (set wins).
  - Display priority is never overridden.
- Reset mid-operation drops any buffered write and any in-flight read. No ACK or VALID is issued for them.

## Timing
- Request sampled at edge k → oMEM_ADDR/oMEM_WE are registered and valid after edge k. iMEM_RDATA arrives after edge k+1.
- Read data is registered at edge k+2. oDISP_VALID (or oHOST_ACK for reads) pulses for one cycle after edge k+2. Read latency is exactly 2 cycles.
- Write ack: oHOST_ACK pulses after the capture edge. The drain happens at the earliest slot with no display request, at minimum one cycle after capture.
- Display requests with DCLK = clk/2 leave every other slot free. Host throughput is ≥ one access per 2 cycles in that case.
- Back-to-back display requests every cycle are legal. The host then stalls and the starvation flag may set.

## Structure
- Shared package lcd_pkg:
  - H/V pixel constants 800/480.
  - ABW and DW defaults.
  - Grant encoding enum {G_IDLE, G_DISP, G_WDRAIN, G_HRD}.
- Sub-module vram_wbuf: the one-entry posted write buffer.
  - Inputs: load, drain.
  - Outputs: full, addr, data.
  - Has an asynchronous rst_.
- The read-return pipeline is a 2-stage tagged shift register of the grant type, driving the DISP/HOST steering.

## Test plan
- Display-only: iDISP_REQ every cycle with addresses 0..7 and VRAM model data = addr → oDISP_VALID 2 cycles after each request, colours 0..7 in order, oMEM_WE never 1.
- Posted write then read: host writes 0x00ABCD to addr 100, then reads 100 with no display traffic → write ACK after 1 cycle, oMEM_WE pulse, read ACK with RDATA=0x00ABCD; the read is never issued before the drain.
- Interleave: display at clk/2 plus continuous host writes to 0..15 → no display latency change, all 16 writes land in VRAM, ACK spacing ≥2.
- Starvation: display REQ held high for 70 cycles with a host read pending → oHOST_STARVE sets at the 64th waiting cycle, read completes after display stops, flag clears on iSTARVE_CLR.
- Reset mid-op: assert rst_ low while the buffer is full and a read is in flight → all outputs 0 immediately, no ACK/VALID after release, VRAM not written.
